// File: rtl/mem_access_stage_if.sv
// rtl/mem_access_stage_if.sv - data memory request/ready bus between the memory stage and data memory
interface mem_access_stage_if;
  logic        req;
  logic        we;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [3:0]  size;
  logic        ready;
  logic [63:0] rdata;

  modport master (output req, we, addr, wdata, size, input ready, rdata);
  modport slave  (input req, we, addr, wdata, size, output ready, rdata);
endinterface

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - pipeline memory stage with dmem handshake, stall and MEM/WB register (optional MEM_TIMEOUT_EN abort)
module mem_access_stage #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               MEM_RegWrite,
  input  logic               MEM_MemWrite,
  input  logic               MEM_MemToReg,
  input  logic               MEM_read_enable,
  input  logic               MEM_NOOP,
  input  logic [3:0]         MEM_xfer_size,
  input  logic [4:0]         MEM_Rd,
  input  logic [63:0]        MEM_ALUResult_out,
  input  logic [63:0]        MEM_RegB_content,
  mem_access_stage_if.master dmem,
  output logic               mem_stall,
  output logic               WB_RegWrite,
  output logic [4:0]         WB_Rd,
  output logic [63:0]        WB_Data,
  output logic               WB_NOOP,
  output logic               mem_error
);

  typedef enum logic {IDLE, REQ} state_t;

  state_t      state, state_next;
  logic        pending;
  logic        done;
  logic        abort;
  logic [3:0]  size_norm;
  logic [63:0] wdata_masked;
  logic [63:0] load_data;
  logic [63:0] addr_q, wdata_q;
  logic [3:0]  size_q;
  logic        we_q;

  assign pending = (MEM_read_enable | MEM_MemWrite) & ~MEM_NOOP;
  assign done    = (state == REQ) & dmem.ready;

  // Normalise the access width (illegal widths become 8) and mask store data to it
  always_comb begin
    size_norm    = 4'd8;
    wdata_masked = MEM_RegB_content;
    case (MEM_xfer_size)
      4'd1:    size_norm = 4'd1;
      4'd2:    size_norm = 4'd2;
      4'd4:    size_norm = 4'd4;
      default: size_norm = 4'd8;
    endcase
    case (size_norm)
      4'd1:    wdata_masked = {56'd0, MEM_RegB_content[7:0]};
      4'd2:    wdata_masked = {48'd0, MEM_RegB_content[15:0]};
      4'd4:    wdata_masked = {32'd0, MEM_RegB_content[31:0]};
      default: wdata_masked = MEM_RegB_content;
    endcase
  end

  // Zero-extend the right-aligned load data to the latched access width
  always_comb begin
    load_data = dmem.rdata;
    case (size_q)
      4'd1:    load_data = {56'd0, dmem.rdata[7:0]};
      4'd2:    load_data = {48'd0, dmem.rdata[15:0]};
      4'd4:    load_data = {32'd0, dmem.rdata[31:0]};
      default: load_data = dmem.rdata;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  logic [7:0] tmo_cnt;

  // The access aborts in the REQ cycle that would bring the counter to TIMEOUT
  assign abort = (state == REQ) & ~dmem.ready & (tmo_cnt == 8'(TIMEOUT - 1));

  // Count REQ cycles spent waiting for ready, restarting on each new access
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      tmo_cnt <= 8'd0;
    else if (state == IDLE && pending)
      tmo_cnt <= 8'd0;
    else if (state == REQ && !dmem.ready)
      tmo_cnt <= tmo_cnt + 8'd1;
  end

  // Sticky error flag, cleared only by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      mem_error <= 1'b0;
    else if (abort)
      mem_error <= 1'b1;
  end
`else
  assign abort     = 1'b0;
  assign mem_error = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  // FSM next-state: issue on a pending access, finish on ready or abort
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pending) state_next = REQ;
      REQ:     if (done || abort) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Latch request fields on issue so the bus stays stable for the whole REQ state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= 64'd0;
      wdata_q <= 64'd0;
      size_q  <= 4'd0;
      we_q    <= 1'b0;
    end else if (state == IDLE && pending) begin
      addr_q  <= MEM_ALUResult_out;
      wdata_q <= wdata_masked;
      size_q  <= size_norm;
      we_q    <= MEM_MemWrite;
    end
  end

  assign dmem.req   = (state == REQ);
  assign dmem.we    = we_q;
  assign dmem.addr  = addr_q;
  assign dmem.wdata = wdata_q;
  assign dmem.size  = size_q;

  // Stall is gated by reset so it drops together with dmem.req on an asynchronous reset
  assign mem_stall = ~reset & (((state == IDLE) & pending) | ((state == REQ) & ~dmem.ready & ~abort));

  // MEM/WB register: bubble while stalled or on abort, otherwise take the instruction
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      WB_RegWrite <= 1'b0;
      WB_Rd       <= 5'd0;
      WB_Data     <= 64'd0;
      WB_NOOP     <= 1'b1;
    end else if (mem_stall || abort) begin
      WB_RegWrite <= 1'b0;
      WB_NOOP     <= 1'b1;
    end else begin
      WB_RegWrite <= MEM_RegWrite & ~MEM_NOOP;
      WB_Rd       <= MEM_Rd;
      WB_NOOP     <= MEM_NOOP;
      WB_Data     <= (MEM_MemToReg && !we_q && done) ? load_data : MEM_ALUResult_out;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - randomized self-checking bench for mem_access_stage
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MEM_RegWrite = 0, MEM_MemWrite = 0, MEM_MemToReg = 0, MEM_read_enable = 0, MEM_NOOP = 0;
  logic [3:0]  MEM_xfer_size = 0;
  logic [4:0]  MEM_Rd = 0;
  logic [63:0] MEM_ALUResult_out = 0, MEM_RegB_content = 0;
  logic        mem_stall, WB_RegWrite, WB_NOOP, mem_error;
  logic [4:0]  WB_Rd;
  logic [63:0] WB_Data;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] prev_data = 0;
  logic [4:0]  prev_rd = 0;
  logic        exp_err = 0;

  mem_access_stage_if dmem ();

  mem_access_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .MEM_RegWrite(MEM_RegWrite), .MEM_MemWrite(MEM_MemWrite), .MEM_MemToReg(MEM_MemToReg),
    .MEM_read_enable(MEM_read_enable), .MEM_NOOP(MEM_NOOP), .MEM_xfer_size(MEM_xfer_size),
    .MEM_Rd(MEM_Rd), .MEM_ALUResult_out(MEM_ALUResult_out), .MEM_RegB_content(MEM_RegB_content),
    .dmem(dmem), .mem_stall(mem_stall), .WB_RegWrite(WB_RegWrite), .WB_Rd(WB_Rd),
    .WB_Data(WB_Data), .WB_NOOP(WB_NOOP), .mem_error(mem_error)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit rw, mw, m2r, rd_en, noop, input logic [3:0] xs,
                       input logic [4:0] rd, input logic [63:0] alu, regb);
    MEM_RegWrite = rw; MEM_MemWrite = mw; MEM_MemToReg = m2r; MEM_read_enable = rd_en;
    MEM_NOOP = noop; MEM_xfer_size = xs; MEM_Rd = rd; MEM_ALUResult_out = alu; MEM_RegB_content = regb;
  endtask

  // One instruction held on MEM_* until it leaves; memory answers n cycles into REQ.
  task automatic do_op(input bit rw, mw, m2r, rd_en, noop, input logic [3:0] xs,
                       input logic [4:0] rd, input logic [63:0] alu, regb,
                       input int n, input logic [63:0] rdata);
    bit          pend;
    logic [3:0]  b;
    logic [63:0] exp_wd, exp_data;
    int          stalls;
    pend     = (rd_en || mw) && !noop;
    b        = (xs == 1 || xs == 2 || xs == 4 || xs == 8) ? xs : 4'd8;
    exp_wd   = 64'(regb % (128'd1 << (8 * b)));
    exp_data = (pend && m2r && !mw) ? 64'(rdata % (128'd1 << (8 * b))) : alu;
    drive(rw, mw, m2r, rd_en, noop, xs, rd, alu, regb);
    dmem.ready = 1'b0;
    #1;
    check("req_low_idle", dmem.req, 1'b0);
    if (!pend) begin
      check("stall_no_access", mem_stall, 1'b0);
      @(posedge clk); #1;
    end else begin
      stalls = mem_stall ? 1 : 0;
      @(posedge clk); #1;
      for (int k = 0; k <= n; k++) begin
        check("req_high", dmem.req, 1'b1);
        check("addr", dmem.addr, alu);
        check("wdata", dmem.wdata, exp_wd);
        check("size", dmem.size, 64'(b));
        check("we", dmem.we, mw);
        if (k == 0) begin
          check("bubble_noop", WB_NOOP, 1'b1);
          check("bubble_regwrite", WB_RegWrite, 1'b0);
          check("hold_rd", WB_Rd, prev_rd);
          check("hold_data", WB_Data, prev_data);
        end
        if (k == n) begin
          dmem.ready = 1'b1;
          dmem.rdata = rdata;
        end else begin
          dmem.rdata = {$urandom, $urandom};
        end
        #1;
        if (mem_stall) stalls++;
        @(posedge clk); #1;
      end
      dmem.ready = 1'b0;
      check("stall_cycles", 64'(stalls), 64'(n + 1));
    end
    check("wb_regwrite", WB_RegWrite, rw && !noop);
    check("wb_rd", WB_Rd, rd);
    check("wb_data", WB_Data, exp_data);
    check("wb_noop", WB_NOOP, noop);
    check("mem_error", mem_error, exp_err);
    prev_data = exp_data;
    prev_rd   = rd;
  endtask

  initial begin
    bit          rd_en, mw, noop;
    logic [3:0]  xs;
    logic [3:0]  legal [4] = '{4'd1, 4'd2, 4'd4, 4'd8};
    dmem.ready = 1'b0;
    dmem.rdata = 64'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", dmem.req, 1'b0);
    check("rst_we", dmem.we, 1'b0);
    check("rst_addr", dmem.addr, 64'd0);
    check("rst_wdata", dmem.wdata, 64'd0);
    check("rst_size", dmem.size, 64'd0);
    check("rst_stall", mem_stall, 1'b0);
    check("rst_wb_regwrite", WB_RegWrite, 1'b0);
    check("rst_wb_rd", WB_Rd, 5'd0);
    check("rst_wb_data", WB_Data, 64'd0);
    check("rst_wb_noop", WB_NOOP, 1'b1);
    check("rst_mem_error", mem_error, 1'b0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    // Directed: ALU op, load, store, NOOP read, back-to-back with illegal size and read+write.
    do_op(1, 0, 0, 0, 0, 4'd8, 5'd5, 64'h1234, 64'd0, 0, 64'd0);
    do_op(1, 0, 1, 1, 0, 4'd2, 5'd7, 64'h40, 64'd0, 2, 64'hFFFF_FFFF_FFFF_ABCD);
    do_op(0, 1, 0, 0, 0, 4'd1, 5'd0, 64'h80, 64'hFFFF_FFFF_FFFF_FF5A, 0, 64'd0);
    do_op(0, 0, 0, 1, 1, 4'd4, 5'd9, 64'h99, 64'd0, 0, 64'd0);
    do_op(1, 0, 1, 1, 0, 4'd3, 5'd3, 64'h100, 64'd0, 1, 64'h8877_6655_4433_2211);
    do_op(1, 1, 1, 1, 0, 4'd4, 5'd4, 64'h108, 64'hDEAD_BEEF_CAFE_F00D, 0, 64'h1111_2222_3333_4444);

    for (int i = 0; i < 40; i++) begin
      rd_en = 1'($urandom);
      mw    = 1'($urandom);
      noop  = ($urandom_range(0, 5) == 0);
      xs    = ($urandom_range(0, 4) == 0) ? 4'($urandom) : legal[$urandom_range(0, 3)];
      do_op(1'($urandom), mw, ((rd_en || mw) && !noop) ? 1'($urandom) : 1'b0, rd_en, noop, xs,
            5'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
            $urandom_range(0, 3), {$urandom, $urandom});
    end

    // Asynchronous reset while a load is in REQ.
    drive(1, 0, 1, 1, 0, 4'd8, 5'd1, 64'h200, 64'd0);
    #1;
    @(posedge clk); #1;
    check("pre_reset_req", dmem.req, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("async_req_drop", dmem.req, 1'b0);
    check("async_stall_drop", mem_stall, 1'b0);
    drive(0, 0, 0, 0, 1, 4'd8, 5'd0, 64'd0, 64'd0);
    @(negedge clk) reset = 1'b0;
    #1;
    check("post_reset_noop", WB_NOOP, 1'b1);
    check("post_reset_regwrite", WB_RegWrite, 1'b0);
    check("post_reset_req", dmem.req, 1'b0);
    prev_data = 64'd0;
    prev_rd   = 5'd0;
    @(posedge clk); #1;
    do_op(1, 0, 1, 1, 0, 4'd4, 5'd12, 64'h300, 64'd0, 1, 64'hAAAA_BBBB_CCCC_DDDD);

`ifdef MEM_TIMEOUT_EN
    begin
      int cycles;
      cycles = 0;
      drive(1, 0, 1, 1, 0, 4'd8, 5'd2, 64'h400, 64'd0);
      dmem.ready = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < 20; i++) begin
        if (dmem.req) cycles++;
        if (!mem_stall) break;
        @(posedge clk); #1;
      end
      check("tmo_req_cycles", 64'(cycles), 64'd4);
      @(posedge clk); #1;
      drive(0, 0, 0, 0, 0, 4'd8, 5'd0, 64'd0, 64'd0);
      exp_err = 1'b1;
      #1;
      check("tmo_req_drop", dmem.req, 1'b0);
      check("tmo_error", mem_error, 1'b1);
      check("tmo_bubble_noop", WB_NOOP, 1'b1);
      check("tmo_bubble_regwrite", WB_RegWrite, 1'b0);
      @(posedge clk); #1;
      prev_data = 64'd0;
      prev_rd   = 5'd0;
      do_op(1, 0, 0, 0, 0, 4'd8, 5'd6, 64'h5555, 64'd0, 0, 64'd0);
      do_op(1, 0, 1, 1, 0, 4'd1, 5'd8, 64'h408, 64'd0, 1, 64'h0123_4567_89AB_CDEF);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
